// File: rtl/tdm_demux.sv
// tdm_demux: receiving end of a slot-multiplexed link.
// A serial stream of W-bit beats is split into frames of N_CH slots; the
// beat flagged with frame_start is slot 0 and slot i lands in channel i.
//
// Handshake: din_valid qualifies din and frame_start for one cycle. There is
// no ready signal; the block accepts one beat every clock it is offered, and
// frame_start is ignored on cycles where din_valid is low.
//
// Build option: define TDM_DEMUX_FRAME_LATCH_EN to stage slots in a shadow
// register and publish a whole frame at once on completion. When it is left
// undefined, each accepted slot writes its channel register directly.
//
// state_dbg exposes the FSM (0 = IDLE, 1 = RUN) for observation.

module tdm_demux #(
    parameter int N_CH = 8,
    parameter int W    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_start,
    output logic [N_CH*W-1:0] ch_data,
    output logic [N_CH-1:0]   ch_valid,
    output logic              frame_done,
    output logic              frame_err,
    output logic              state_dbg
);

    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [N_CH-1:0] ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [SW-1:0]    slot, slot_n;

    // Decoded action for the current beat.
    logic             cap;
    logic [SW-1:0]    cap_idx;
    logic             done_n;
    logic             err_n;

    // Next values of the registered outputs.
    logic [N_CH*W-1:0] ch_data_n;
    logic [N_CH-1:0]   ch_valid_n;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    logic [N_CH*W-1:0] shadow, shadow_n;
`endif

    // State and slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
        end
    end

    // Next-state decode: which slot (if any) this beat fills and which pulses fire.
    always_comb begin
        state_n = state;
        slot_n  = slot;
        cap     = 1'b0;
        cap_idx = '0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (din_valid) begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        cap     = 1'b1;
                        cap_idx = '0;
                        slot_n  = SLOT_ONE;
                        state_n = RUN;
                    end else begin
                        // Orphan beat with no frame context: drop it.
                        err_n = 1'b1;
                    end
                end
                RUN: begin
                    if (frame_start) begin
                        // Early restart: abandon the partial frame, this beat is slot 0.
                        err_n   = 1'b1;
                        cap     = 1'b1;
                        cap_idx = '0;
                        slot_n  = SLOT_ONE;
                    end else begin
                        cap     = 1'b1;
                        cap_idx = slot;
                        if (slot == LAST_SLOT) begin
                            done_n  = 1'b1;
                            slot_n  = '0;
                            state_n = IDLE;
                        end else begin
                            slot_n = slot + SLOT_ONE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    slot_n  = '0;
                end
            endcase
        end
    end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    // Stage slots in the shadow; publish the complete frame only on completion.
    always_comb begin
        shadow_n   = shadow;
        ch_data_n  = ch_data;
        ch_valid_n = '0;
        if (cap) begin
            shadow_n[cap_idx*W +: W] = din;
        end
        if (done_n) begin
            ch_data_n  = shadow_n;
            ch_valid_n = '1;
        end
    end

    // Shadow register holding the frame under assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else begin
            shadow <= shadow_n;
        end
    end
`else
    // Write each accepted slot straight into its channel and strobe that channel.
    always_comb begin
        ch_data_n  = ch_data;
        ch_valid_n = '0;
        if (cap) begin
            ch_data_n[cap_idx*W +: W] = din;
            ch_valid_n                = ONE_HOT0 << cap_idx;
        end
    end
`endif

    // Registered outputs: one cycle after the accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data    <= '0;
            ch_valid   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            ch_data    <= ch_data_n;
            ch_valid   <= ch_valid_n;
            frame_done <= done_n;
            frame_err  <= err_n;
        end
    end

    assign state_dbg = (state == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed frames against a scoreboard of hand-computed
// expected output events (N_CH=4, W=4, default build).

module tb_tdm_demux;

    localparam int N_CH = 4;
    localparam int W    = 4;
    localparam int EW   = 1 + N_CH + 2 + N_CH*W;  // {state, valid, done, err, data}

    logic              clk;
    logic              rst_n;
    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_start;
    logic [N_CH*W-1:0] ch_data;
    logic [N_CH-1:0]   ch_valid;
    logic              frame_done;
    logic              frame_err;
    logic              state_dbg;

    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic          tb_done  = 1'b0;

    tdm_demux #(.N_CH(N_CH), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .state_dbg   (state_dbg)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: all are entered 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic fs,
                        input logic exp_state, input logic [N_CH-1:0] exp_valid,
                        input logic exp_done, input logic exp_err,
                        input logic [N_CH*W-1:0] exp_data);
        din         = d;
        frame_start = fs;
        din_valid   = 1'b1;
        exp_q.push_back({exp_state, exp_valid, exp_done, exp_err, exp_data});
        tick(1);
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Scoreboard / monitor: sole owner of the counters.
    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got state=%0b valid=%b done=%0b err=%0b data=%h, expected state=%0b valid=%b done=%0b err=%0b data=%h",
                     name,
                     act[EW-1], act[EW-2 -: N_CH], act[N_CH*W+1], act[N_CH*W], act[N_CH*W-1:0],
                     exp[EW-1], exp[EW-2 -: N_CH], exp[N_CH*W+1], exp[N_CH*W], exp[N_CH*W-1:0]);
        end
    endtask

    always begin
        logic [EW-1:0] act;
        logic [EW-1:0] exp;
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            act = {state_dbg, ch_valid, frame_done, frame_err, ch_data};
            check("reset_outputs_zero", act, '0);
        end else if (tb_done) begin
            n_checks++;
            if (exp_q.size() == 0) n_pass++;
            else $display("FAIL queue_drained: %0d events outstanding, expected 0", exp_q.size());
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end else if (|ch_valid || frame_done || frame_err) begin
            act = {state_dbg, ch_valid, frame_done, frame_err, ch_data};
            if (exp_q.size() == 0) begin
                check("unexpected_output", act, '0);
            end else begin
                exp = exp_q.pop_front();
                check("output_event", act, exp);
            end
        end
    end

    // Stimulus
    initial begin
        rst_n       = 1'b0;
        din         = '0;
        din_valid   = 1'b1;
        frame_start = 1'b0;

        // Reset held with random traffic: outputs must remain zero.
        repeat (4) begin
            din         = W'($urandom_range(0, 15));
            frame_start = 1'(($urandom_range(0, 1)));
            @(posedge clk);
            #1;
        end
        din_valid   = 1'b0;
        frame_start = 1'b0;
        rst_n       = 1'b1;
        tick(1);

        // First frame after reset
        send(4'h1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h0001);
        send(4'h2, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h0021);
        send(4'h3, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'h0321);
        send(4'h4, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h4321);
        tick(2);

        // Back-to-back frames with no gap
        send(4'hA, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h432A);
        send(4'hB, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h43BA);
        send(4'hC, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'h4CBA);
        send(4'hD, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'hDCBA);
        send(4'h5, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'hDCB5);
        send(4'h6, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'hDC65);
        send(4'h7, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'hD765);
        send(4'h8, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h8765);
        tick(2);

        // Gaps of 3 idle cycles between beats
        send(4'h1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h8761);
        tick(3);
        send(4'h2, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h8721);
        tick(3);
        send(4'h3, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'h8321);
        tick(3);
        send(4'h4, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h4321);
        tick(2);

        // Early restart
        send(4'h1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h4321);
        send(4'h2, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h4321);
        send(4'h9, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 16'h4329);
        send(4'hA, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h43A9);
        send(4'hB, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'h4BA9);
        send(4'hC, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'hCBA9);
        tick(2);

        // Orphan beat in IDLE, then a proper frame
        send(4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 16'hCBA9);
        tick(1);
        send(4'h5, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'hCBA5);
        send(4'h6, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'hCB65);
        send(4'h7, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'hC765);
        send(4'h8, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h8765);
        tick(2);

        // Reset in the middle of a frame
        send(4'h1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h8761);
        send(4'h2, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h8721);
        tick(1);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send(4'h1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h0001);
        send(4'h2, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 16'h0021);
        send(4'h3, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 16'h0321);
        send(4'h4, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 16'h4321);
        tick(3);

        tb_done = 1'b1;
        tick(5);
        $display("FAIL end_of_test: monitor did not close the run");
        $fatal(1, "monitor did not finish");
    end

endmodule
